// File: rtl/mbc3_rtc_save_tx.sv
// Serializes a snapshot of the MBC3 RTC state into the five-word save record
// (timestamp lo/hi, savedtime lo/hi, commit) for the HPS save-file writer.
module mbc3_rtc_save_tx #(
  parameter logic [15:0] COMMIT_WORD = 16'h0001,
  parameter logic [7:0]  FIRST_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        save_req,
  input  logic [31:0] RTC_timestamp,
  input  logic [47:0] RTC_savedtime,
  input  logic        RTC_inuse,
  output logic        rtc_valid,
  input  logic        rtc_ready,
  output logic [7:0]  rtc_addr,
  output logic [15:0] rtc_data,
  output logic        busy,
  output logic        done,
  output logic        skipped
);

  typedef enum logic [1:0] {IDLE, SNAP, SEND, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  idx;
  logic [31:0] ts_q;
  logic [31:0] st_q;
  logic        skip_q;
  logic        unused_hi;

  // The upper savedtime bits are not part of the record.
  assign unused_hi = ^RTC_savedtime[47:32];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= 3'd0;
      ts_q   <= 32'd0;
      st_q   <= 32'd0;
      skip_q <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (save_req) skip_q <= 1'b0;
        SNAP: begin
          if (ce_cpu) begin
            ts_q   <= RTC_timestamp;
            st_q   <= RTC_savedtime[31:0];
            skip_q <= ~RTC_inuse;
            idx    <= 3'd0;
          end
        end
        SEND: if (rtc_ready && idx != 3'd4) idx <= idx + 3'd1;
        DONE: idx <= 3'd0;
        default: idx <= 3'd0;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (save_req) next_state = SNAP;
      SNAP: if (ce_cpu) next_state = RTC_inuse ? SEND : DONE;
      SEND: if (rtc_ready && idx == 3'd4) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every transmitted word is taken from the holding registers, never the live RTC.
  always_comb begin
    rtc_valid = (state == SEND);
    busy      = (state == SNAP) || (state == SEND);
    done      = (state == DONE);
    skipped   = skip_q;
    rtc_addr  = FIRST_INDEX + {5'd0, idx};
    rtc_data  = 16'd0;
    if (state == SEND) begin
      case (idx)
        3'd0:    rtc_data = ts_q[15:0];
        3'd1:    rtc_data = ts_q[31:16];
        3'd2:    rtc_data = st_q[15:0];
        3'd3:    rtc_data = st_q[31:16];
        default: rtc_data = COMMIT_WORD;
      endcase
    end
  end

endmodule

// File: tb/tb_mbc3_rtc_save_tx.sv
// Self-checking bench for mbc3_rtc_save_tx: table of save records plus hand-written
// reset-abort sequence; accepted words are checked against a scoreboard queue.
module tb_mbc3_rtc_save_tx;

  logic        clk_sys;
  logic        reset_n;
  logic        ce_cpu;
  logic        save_req;
  logic [31:0] RTC_timestamp;
  logic [47:0] RTC_savedtime;
  logic        RTC_inuse;
  logic        rtc_valid;
  logic        rtc_ready;
  logic [7:0]  rtc_addr;
  logic [15:0] rtc_data;
  logic        busy;
  logic        done;
  logic        skipped;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } word_t;

  typedef struct {
    logic [31:0] ts;
    logic [47:0] st;
    logic        inuse;
    int          stall;
    int          ce_delay;
    bit          ts_change;
    bit          extra_req;
    logic        exp_skipped;
    int          exp_first;
    int          exp_done;
  } vec_t;

  word_t exp_q[$];
  vec_t  vecs[6];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stall_len = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_skip = 1'b0;
  bit seen_valid = 1'b0;
  int first_valid_cyc = 0;

  mbc3_rtc_save_tx dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ce_cpu(ce_cpu),
    .save_req(save_req),
    .RTC_timestamp(RTC_timestamp),
    .RTC_savedtime(RTC_savedtime),
    .RTC_inuse(RTC_inuse),
    .rtc_valid(rtc_valid),
    .rtc_ready(rtc_ready),
    .rtc_addr(rtc_addr),
    .rtc_data(rtc_data),
    .busy(busy),
    .done(done),
    .skipped(skipped)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writer model: stalls each word for stall_len cycles, then accepts and scores it.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      rtc_ready = 1'b1;
      stall_cnt = 0;
    end else begin
      if (rtc_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          first_valid_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", {40'd0, rtc_addr, rtc_data}, 64'hFFFF_FFFF_FFFF_FFFF);
          rtc_ready = 1'b1;
        end else if (stall_cnt < stall_len) begin
          rtc_ready = 1'b0;
          stall_cnt++;
          check_output("stall_addr", {56'd0, rtc_addr}, {56'd0, exp_q[0].addr});
          check_output("stall_data", {48'd0, rtc_data}, {48'd0, exp_q[0].data});
        end else begin
          word_t w;
          rtc_ready = 1'b1;
          stall_cnt = 0;
          w = exp_q.pop_front();
          check_output("word_addr", {56'd0, rtc_addr}, {56'd0, w.addr});
          check_output("word_data", {48'd0, rtc_data}, {48'd0, w.data});
        end
      end else begin
        rtc_ready = 1'b1;
        stall_cnt = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_skip = skipped;
      end
    end
  end

  task automatic push_record(input logic [31:0] ts, input logic [47:0] st);
    logic [15:0] words [5];
    words[0] = ts[15:0];
    words[1] = ts[31:16];
    words[2] = st[15:0];
    words[3] = st[31:16];
    words[4] = 16'h0001;
    for (int i = 0; i < 5; i++) exp_q.push_back('{addr: 8'(i), data: words[i]});
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int req_cyc;
    int d0;
    int rel;
    d0 = done_cnt;
    stall_len = v.stall;
    if (v.inuse) push_record(v.ts, v.st);
    @(negedge clk_sys);
    RTC_timestamp = (v.ce_delay > 0) ? 32'hDEAD_BEEF : v.ts;
    RTC_savedtime = v.st;
    RTC_inuse = v.inuse;
    ce_cpu = (v.ce_delay == 0);
    seen_valid = 1'b0;
    save_req = 1'b1;
    req_cyc = cyc;
    for (int c = 0; c < 400 && done_cnt == d0; c++) begin
      @(negedge clk_sys);
      rel = cyc - req_cyc;
      if (rel == 1) check_output({tag, "_busy"}, {63'd0, busy}, 64'd1);
      save_req = v.extra_req && (rel == 3);
      if (rel == 1 + v.ce_delay) begin
        ce_cpu = 1'b1;
        RTC_timestamp = v.ts;
      end
      if (v.ts_change && rel == 2) RTC_timestamp = v.ts + 32'd1;
    end
    save_req = 1'b0;
    for (int c = 0; c < 10; c++) @(negedge clk_sys);
    check_output({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check_output({tag, "_done_latency"}, 64'(done_cyc - req_cyc), 64'(v.exp_done));
    check_output({tag, "_skipped"}, {63'd0, done_skip}, {63'd0, v.exp_skipped});
    check_output({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
    if (v.exp_first >= 0)
      check_output({tag, "_first_latency"}, 64'(first_valid_cyc - req_cyc), 64'(v.exp_first));
    else
      check_output({tag, "_no_valid"}, {63'd0, seen_valid}, 64'd0);
    check_output({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_valid"}, {63'd0, rtc_valid}, 64'd0);
    check_output({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_output({tag, "_done"}, {63'd0, done}, 64'd0);
    check_output({tag, "_skipped"}, {63'd0, skipped}, 64'd0);
    check_output({tag, "_addr"}, {56'd0, rtc_addr}, 64'd0);
    check_output({tag, "_data"}, {48'd0, rtc_data}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    bit found;
    vecs[0] = '{32'h1234_5678, 48'h0000_0ABC_DEF0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 2, 7};
    vecs[1] = '{32'h1234_5678, 48'h0000_0ABC_DEF0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 2, 22};
    vecs[2] = '{32'h1234_5678, 48'h0000_0ABC_DEF0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, -1, 2};
    vecs[3] = '{32'h1234_5678, 48'h0000_0ABC_DEF0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 2, 7};
    vecs[4] = '{32'h1234_5678, 48'h0000_0ABC_DEF0, 1'b1, 0, 10, 1'b0, 1'b0, 1'b0, 12, 17};
    vecs[5] = '{32'hFFFF_FFFF, 48'hFFFF_8000_0001, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 2, 12};

    reset_n = 1'b0;
    ce_cpu = 1'b1;
    save_req = 1'b0;
    RTC_timestamp = 32'h0;
    RTC_savedtime = 48'h0;
    RTC_inuse = 1'b0;
    rtc_ready = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_reset_state("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Abort a record with reset while word 2 is on the bus.
    d0 = done_cnt;
    stall_len = 0;
    push_record(32'hCAFE_F00D, 48'h0000_1357_2468);
    @(negedge clk_sys);
    RTC_timestamp = 32'hCAFE_F00D;
    RTC_savedtime = 48'h0000_1357_2468;
    RTC_inuse = 1'b1;
    save_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_sys);
      save_req = 1'b0;
      if (rtc_valid && rtc_addr == 8'd2) found = 1'b1;
    end
    check_output("abort_reached_word2", {63'd0, found}, 64'd1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_reset_state("abort");
    reset_n = 1'b1;
    exp_q.delete();
    repeat (6) @(negedge clk_sys);
    check_output("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_output("abort_idle_valid", {63'd0, rtc_valid}, 64'd0);

    apply_stimulus(vecs[0], "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
